shift_rows_pipe: RTL and testbench

Parametrised, pipelined Rijndael ShiftRows/InvShiftRows unit with valid/ready flow control. It supports block widths of 4, 6 or 8 columns, selects forward or inverse permutation per block, and carries the mode bit alongside the data. It sits between the SubBytes and MixColumns stages of the round datapath and replaces the fixed 128-bit inverse-only combinational permutation.

---
 rtl/shift_rows_pipe.sv | 111 +++++++++++
 tb/tb_shift_rows_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for 4, 6 or 8 column states with valid/ready flow.
// The byte permutation sits in front of stage 1; later stages carry the block and its mode bit forward.
module shift_rows_pipe #(
  parameter int unsigned NB     = 4,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [32*NB-1:0]  out_state,
  output logic              busy
);

  localparam int unsigned W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4");
  end

  // Row rotation amount; only the 8-column state uses the wider offsets on rows 2 and 3.
  function automatic int unsigned row_shift(input int unsigned r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [W-1:0]             perm_state;
  logic [STAGES:0]          rdy;
  logic [STAGES:0]          src_v;
  logic [STAGES:0]          src_inv;
  logic [STAGES:0][W-1:0]   src_data;

  logic [STAGES-1:0]        v_q,    v_d;
  logic [STAGES-1:0]        inv_q,  inv_d;
  logic [STAGES-1:0][W-1:0] data_q, data_d;

  // Byte (r,c) lives at bits [W-1-8*(4c+r) -: 8]; row r rotates left (forward) or right (inverse).
  always_comb begin : permute
    perm_state = '0;
    for (int unsigned c = 0; c < NB; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        perm_state[W-1-8*(4*c+r) -: 8] = in_inv
          ? in_state[W-1-8*(4*((c + NB - row_shift(r)) % NB) + r) -: 8]
          : in_state[W-1-8*(4*((c + row_shift(r)) % NB) + r) -: 8];
      end
    end
  end

  // Ready ripples back from the output: a stage can take a block if empty or if it drains this cycle.
  always_comb begin : ready_chain
    logic carry;
    carry       = out_ready;
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      carry                = ~v_q[STAGES-1-k] | carry;
      rdy[STAGES-1-k]      = carry;
    end
  end

  // Entry i of the src_* vectors is what stage i would load: the permuted input for stage 0.
  assign src_v    = {v_q, in_valid};
  assign src_inv  = {inv_q, in_inv};
  assign src_data = {data_q, perm_state};

  always_comb begin : next_state
    v_d    = v_q;
    inv_d  = inv_q;
    data_d = data_q;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (rdy[i]) begin
        v_d[i] = src_v[i] & ~clr;
        if (src_v[i] && !clr) begin
          inv_d[i]  = src_inv[i];
          data_d[i] = src_data[i];
        end
      end
      if (clr) begin
        v_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      v_q    <= '0;
      inv_q  <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      inv_q  <= inv_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = rdy[0] & ~rst;
  assign out_valid = v_q[STAGES-1];
  assign out_inv   = inv_q[STAGES-1];
  assign out_state = data_q[STAGES-1];
  assign busy      = |v_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: three configurations checked against a byte-level ShiftRows model.
// A = NB 4 / 1 stage, B = NB 8 / 3 stages, C = NB 6 / 2 stages.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_busy;
  logic [127:0] a_in_state, a_out_state;
  logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_busy;
  logic [255:0] b_in_state, b_out_state;
  logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv, c_busy;
  logic [191:0] c_in_state, c_out_state;

  int nerr = 0;
  int nchk = 0;
  int a_out_cnt = 0;
  int b_out_cnt = 0;
  int c_out_cnt = 0;

  logic [256:0] qa[$];
  logic [256:0] qb[$];
  logic [256:0] qc[$];

  localparam logic [127:0] X4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] F4 = 128'h00050a0f_04090e03_080d0207_0c01060b;
  localparam logic [127:0] I4 = 128'h000d0a07_04010e0b_0805020f_0c090603;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_state(a_in_state),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inv(a_out_inv), .out_state(a_out_state),
    .busy(a_busy));

  shift_rows_pipe #(.NB(8), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_state(b_in_state),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv), .out_state(b_out_state),
    .busy(b_busy));

  shift_rows_pipe #(.NB(6), .STAGES(2)) u_c (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv), .in_state(c_in_state),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_inv(c_out_inv), .out_state(c_out_state),
    .busy(c_busy));

  // Reference ShiftRows on an nb-column state held in the low 32*nb bits.
  function automatic logic [255:0] model_perm(input int nb, input logic inv, input logic [255:0] s);
    logic [7:0]   b [32];
    logic [255:0] o;
    int           sh [4];
    int           src;
    sh[0] = 0; sh[1] = 1;
    if (nb == 8) begin sh[2] = 3; sh[3] = 4; end
    else         begin sh[2] = 2; sh[3] = 3; end
    for (int k = 0; k < 32; k++) b[k] = 8'h00;
    for (int k = 0; k < 4*nb; k++) b[k] = s[8*(4*nb-1-k) +: 8];
    o = '0;
    for (int c = 0; c < nb; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        o[8*(4*nb-1-(4*c+r)) +: 8] = b[4*src+r];
      end
    end
    return o;
  endfunction

  // Test block j for an nb-column state: byte k = 32*j + k.
  function automatic logic [255:0] blk(input int nb, input int j);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 4*nb; k++) v[8*(4*nb-1-k) +: 8] = 8'(j*32 + k);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic cmp_out(input string nm, input logic ov, input logic [255:0] os, input logic oi,
                         input logic bz, input int qsz, input logic [256:0] front);
    if (ov) begin
      nchk++;
      if (qsz == 0) begin
        nerr++;
        $display("FAIL %s extra output: got valid block %h with nothing in flight, required none", nm, os);
      end else if (os !== front[255:0] || oi !== front[256]) begin
        nerr++;
        $display("FAIL %s output: got %h inv=%0b required %h inv=%0b", nm, os, oi, front[255:0], front[256]);
      end
    end
    nchk++;
    if (bz !== (qsz != 0)) begin
      nerr++;
      $display("FAIL %s busy: got %0b required %0b", nm, bz, qsz != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the head of each in-flight queue, then account for this cycle's transfers.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      cmp_out("A", a_out_valid, 256'(a_out_state), a_out_inv, a_busy, qa.size(), qa.size() != 0 ? qa[0] : '0);
      cmp_out("B", b_out_valid, b_out_state, b_out_inv, b_busy, qb.size(), qb.size() != 0 ? qb[0] : '0);
      cmp_out("C", c_out_valid, 256'(c_out_state), c_out_inv, c_busy, qc.size(), qc.size() != 0 ? qc[0] : '0);
      if (a_out_valid && a_out_ready && qa.size() != 0) begin void'(qa.pop_front()); a_out_cnt++; end
      if (b_out_valid && b_out_ready && qb.size() != 0) begin void'(qb.pop_front()); b_out_cnt++; end
      if (c_out_valid && c_out_ready && qc.size() != 0) begin void'(qc.pop_front()); c_out_cnt++; end
      if (clr) begin
        qa.delete(); qb.delete(); qc.delete();
      end else begin
        if (a_in_valid && a_in_ready) qa.push_back({a_in_inv, model_perm(4, a_in_inv, 256'(a_in_state))});
        if (b_in_valid && b_in_ready) qb.push_back({b_in_inv, model_perm(8, b_in_inv, b_in_state)});
        if (c_in_valid && c_in_ready) qc.push_back({c_in_inv, model_perm(6, c_in_inv, 256'(c_in_state))});
      end
    end
  end

  initial begin
    bit           acc;
    int           j;
    int           cnt0;
    logic [191:0] hold;

    rst = 1'b1; clr = 1'b0;
    a_in_valid = 0; a_in_inv = 0; a_in_state = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_inv = 0; b_in_state = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_inv = 0; c_in_state = '0; c_out_ready = 1;

    // Model pinned to hand-derived vectors.
    chk("model fwd nb4", model_perm(4, 1'b0, 256'(X4)), 256'(F4));
    chk("model inv nb4", model_perm(4, 1'b1, 256'(X4)), 256'(I4));
    chk("model fwd nb8 col0", 256'(model_perm(8, 1'b0, blk(8, 0)) >> 224), 256'h00050e13);
    chk("model inv nb6 col0", 256'(model_perm(6, 1'b1, blk(6, 0)) >> 160), 256'h0015120f);

    #3;
    chk("reset out_valid", 256'(a_out_valid), 256'd0);
    chk("reset out_state", 256'(a_out_state), 256'd0);
    chk("reset out_inv", 256'(b_out_inv), 256'd0);
    chk("reset busy", 256'(c_busy), 256'd0);
    chk("reset in_ready", 256'(a_in_ready), 256'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 256'(a_in_ready), 256'd1);

    // A: forward, inverse, and an inverse undoing a forward.
    a_in_valid = 1; a_in_inv = 0; a_in_state = X4;
    tick();
    chk("A fwd valid", 256'(a_out_valid), 256'd1);
    chk("A fwd state", 256'(a_out_state), 256'(F4));
    chk("A fwd inv", 256'(a_out_inv), 256'd0);
    a_in_inv = 1;
    tick();
    chk("A inv state", 256'(a_out_state), 256'(I4));
    chk("A inv inv", 256'(a_out_inv), 256'd1);
    a_in_inv = 1; a_in_state = F4;
    tick();
    chk("A round trip", 256'(a_out_state), 256'(X4));
    a_in_valid = 0;
    tick();
    chk("A drained", 256'(a_out_valid), 256'd0);

    // B: three-stage latency, then alternating modes back to back.
    b_in_valid = 1; b_in_inv = 0; b_in_state = blk(8, 0);
    tick();
    b_in_valid = 0;
    chk("B latency edge1", 256'(b_out_valid), 256'd0);
    tick();
    chk("B latency edge2", 256'(b_out_valid), 256'd0);
    tick();
    chk("B latency edge3", 256'(b_out_valid), 256'd1);
    chk("B col0", 256'(b_out_state[255:224]), 256'h00050e13);
    tick();
    for (int k = 0; k < 8; k++) begin
      b_in_valid = 1; b_in_inv = 1'(k); b_in_state = blk(8, k);
      tick();
    end
    b_in_valid = 0;
    for (int t = 0; t < 20 && qb.size() != 0; t++) tick();
    chk("B drained", 256'(qb.size()), 256'd0);
    chk("B output count", 256'(b_out_cnt), 256'd9);

    // C: back-pressure with six blocks.
    c_out_ready = 0; j = 0;
    c_in_valid = 1; c_in_inv = 0; c_in_state = 192'(blk(6, 0));
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      acc = c_in_valid && c_in_ready;
      tick();
      if (acc) j++;
      c_in_state = 192'(blk(6, j)); c_in_inv = 1'(j);
      if (cyc == 1) hold = c_out_state;
      else if (cyc > 1) chk("C stall stable", 256'(c_out_state), 256'(hold));
    end
    chk("C accepts before stall", 256'(j), 256'd2);
    chk("C in_ready when full", 256'(c_in_ready), 256'd0);
    chk("C out_valid when full", 256'(c_out_valid), 256'd1);
    c_out_ready = 1;
    for (int t = 0; t < 40 && (j < 6 || qc.size() != 0); t++) begin
      @(negedge clk);
      acc = c_in_valid && c_in_ready;
      tick();
      if (acc) j++;
      if (j < 6) begin
        c_in_state = 192'(blk(6, j)); c_in_inv = 1'(j);
      end else begin
        c_in_valid = 0;
      end
    end
    chk("C all accepted", 256'(j), 256'd6);
    chk("C all emitted", 256'(c_out_cnt), 256'd6);

    // B: clr with two blocks in flight and a third offered.
    b_in_valid = 1; b_in_inv = 0; b_in_state = blk(8, 1);
    tick();
    b_in_state = blk(8, 2);
    tick();
    clr = 1; b_in_state = blk(8, 3);
    #1;
    chk("B in_ready during clr", 256'(b_in_ready), 256'd1);
    cnt0 = b_out_cnt;
    tick();
    clr = 0; b_in_valid = 0;
    chk("B busy after clr", 256'(b_busy), 256'd0);
    chk("B out_valid after clr", 256'(b_out_valid), 256'd0);
    repeat (5) tick();
    chk("B nothing after clr", 256'(b_out_cnt), 256'(cnt0));

    // B: asynchronous reset mid-stream.
    for (int k = 4; k < 7; k++) begin
      b_in_valid = 1; b_in_inv = 1'(k); b_in_state = blk(8, k);
      tick();
    end
    chk("B streaming before rst", 256'(b_out_valid), 256'd1);
    #1;
    rst = 1;
    #1;
    chk("rst out_valid", 256'(b_out_valid), 256'd0);
    chk("rst out_state", b_out_state, 256'd0);
    chk("rst busy", 256'(b_busy), 256'd0);
    chk("rst in_ready", 256'(b_in_ready), 256'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0; b_in_valid = 0;
    #1;
    chk("B in_ready after rst", 256'(b_in_ready), 256'd1);
    repeat (4) tick();
    chk("A queue empty", 256'(qa.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
